// File: rtl/cpu_pkg.sv
// ============================================================================
// Module      : cpu_pkg
// Description : Shared types and constants for the 16-bit pipelined CPU:
//               branch-condition codes, memory-stage FSM encoding, and
//               default data/register-address widths.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package cpu_pkg;

    // Default datapath widths
    localparam int CPU_DW = 16;
    localparam int CPU_RW = 4;

    // Branch condition codes carried in brType
    localparam logic [2:0] BR_NONE   = 3'b000;
    localparam logic [2:0] BR_EQ     = 3'b001;
    localparam logic [2:0] BR_NE     = 3'b010;
    localparam logic [2:0] BR_GT     = 3'b011;
    localparam logic [2:0] BR_LT     = 3'b100;
    localparam logic [2:0] BR_GE     = 3'b101;
    localparam logic [2:0] BR_LE     = 3'b110;
    localparam logic [2:0] BR_UNCOND = 3'b111;

    // Data-memory handshake FSM encoding
    typedef enum logic [1:0] {
        MEM_IDLE   = 2'd0,
        MEM_ACCESS = 2'd1,
        MEM_DONE   = 2'd2
    } mem_fsm_e;

    // True when the instruction touches data memory
    function automatic logic is_mem_op(input logic re, input logic wr);
        return re | wr;
    endfunction

endpackage

`default_nettype wire

// File: rtl/br_cond_eval.sv
// ============================================================================
// Module      : br_cond_eval
// Description : Combinational branch-condition evaluator. Maps a 3-bit branch
//               code and the registered Z/V/N flags onto a taken decision.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module br_cond_eval
    import cpu_pkg::*;
(
    input  logic [2:0] br_type_i,
    input  logic       zr_i,
    input  logic       ov_i,
    input  logic       neg_i,
    output logic       taken_o
);

    // No current condition code consults overflow; it is kept on the port so
    // signed-compare variants can be added without touching the parent.
    logic w_unused_ov;
    assign w_unused_ov = ov_i;

    // Decode the condition against the flags
    always_comb begin
        taken_o = 1'b0;
        case (br_type_i)
            BR_EQ:     taken_o = zr_i;
            BR_NE:     taken_o = ~zr_i;
            BR_GT:     taken_o = ~zr_i & ~neg_i;
            BR_LT:     taken_o = neg_i;
            BR_GE:     taken_o = zr_i | ~neg_i;
            BR_LE:     taken_o = zr_i | neg_i;
            BR_UNCOND: taken_o = 1'b1;
            default:   taken_o = 1'b0;
        endcase
    end

endmodule

`default_nettype wire

// File: rtl/mem_wb_stage.sv
// ============================================================================
// Module      : mem_wb_stage
// Description : Memory stage and MEM/WB pipeline register. Resolves branches,
//               runs the data-memory req/ack handshake while stalling the
//               upstream pipe, selects write-back data, forwards it, and
//               registers it into the MEM/WB stage.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_wb_stage
    import cpu_pkg::*;
#(
    parameter int DW = CPU_DW,
    parameter int RW = CPU_RW
) (
    input  logic          clk,
    input  logic          rst_n,
    // EX/MEM register outputs
    input  logic [DW-1:0] newAddr,
    input  logic [2:0]    brType,
    input  logic          zr_flag,
    input  logic          ov_flag,
    input  logic          neg_flag,
    input  logic [DW-1:0] aluResult,
    input  logic [DW-1:0] mem_data,
    input  logic [DW-1:0] imAddrIncre,
    input  logic [RW-1:0] dst_addr,
    input  logic          we,
    input  logic          mem_we,
    input  logic          mem_re,
    input  logic          hlt,
    input  logic          labelSel,
    // Data-memory interface
    output logic          dmem_req,
    output logic          dmem_wr,
    output logic [DW-1:0] dmem_addr,
    output logic [DW-1:0] dmem_wdata,
    input  logic          dmem_ack,
    input  logic [DW-1:0] dmem_rdata,
    // Pipeline control
    output logic          stall_mem,
    output logic          pc_redirect,
    output logic [DW-1:0] pc_target,
    output logic          flush_out,
    // Forwarding path
    output logic          fwd_we,
    output logic [RW-1:0] fwd_dst,
    output logic [DW-1:0] fwd_data,
    // MEM/WB register
    output logic          wb_we,
    output logic [RW-1:0] wb_dst,
    output logic [DW-1:0] wb_data,
    output logic          halted
);

    mem_fsm_e      state_q, state_d;
    logic [DW-1:0] rd_q, rd_d;
    logic          wb_we_q, wb_we_d;
    logic [RW-1:0] wb_dst_q, wb_dst_d;
    logic [DW-1:0] wb_data_q, wb_data_d;
    logic          halted_q, halted_d;

    logic          mem_op;
    logic          ack_now;
    logic          br_cond;
    logic [DW-1:0] load_data;
    logic [DW-1:0] wb_sel;

    // A halted core never starts a new memory access, so it also never stalls
    assign mem_op  = is_mem_op(mem_re, mem_we) & ~halted_q;
    assign ack_now = (state_q == MEM_ACCESS) & dmem_ack;

    assign stall_mem = ((state_q == MEM_IDLE) & mem_op) | (state_q == MEM_ACCESS);

    // Memory interface: request is a pure decode of the state register so an
    // asynchronous reset drops it immediately
    assign dmem_req   = (state_q == MEM_ACCESS);
    assign dmem_wr    = dmem_req & mem_we;
    assign dmem_addr  = aluResult;
    assign dmem_wdata = mem_data;

    // Branch resolution; suppressed while stalled so a branch paired with a
    // memory op resolves in the DONE cycle
    br_cond_eval u_br_cond_eval (
        .br_type_i (brType),
        .zr_i      (zr_flag),
        .ov_i      (ov_flag),
        .neg_i     (neg_flag),
        .taken_o   (br_cond)
    );

    assign pc_redirect = br_cond & ~stall_mem;
    assign flush_out   = pc_redirect;
    assign pc_target   = newAddr;

    // Load data bypasses the capture register in the ack cycle
    assign load_data = ack_now ? dmem_rdata : rd_q;
    assign wb_sel    = labelSel ? imAddrIncre : (mem_re ? load_data : aluResult);

    assign fwd_we   = we & ~stall_mem;
    assign fwd_dst  = dst_addr;
    assign fwd_data = wb_sel;

    assign wb_we   = wb_we_q;
    assign wb_dst  = wb_dst_q;
    assign wb_data = wb_data_q;
    assign halted  = halted_q;

    // Next-state logic for the memory handshake FSM and read-data capture
    always_comb begin
        state_d = state_q;
        rd_d    = rd_q;
        case (state_q)
            MEM_IDLE: begin
                if (mem_op) begin
                    state_d = MEM_ACCESS;
                end
            end
            MEM_ACCESS: begin
                if (dmem_ack) begin
                    state_d = MEM_DONE;
                    rd_d    = dmem_rdata;
                end
            end
            MEM_DONE: begin
                state_d = MEM_IDLE;
            end
            default: begin
                state_d = MEM_IDLE;
            end
        endcase
    end

    // Next-state for MEM/WB: retire when not stalled, else insert a bubble
    always_comb begin
        wb_we_d   = 1'b0;
        wb_dst_d  = wb_dst_q;
        wb_data_d = wb_data_q;
        halted_d  = halted_q;
        if (!stall_mem) begin
            wb_we_d   = we;
            wb_dst_d  = dst_addr;
            wb_data_d = wb_sel;
            if (hlt) begin
                halted_d = 1'b1;
            end
        end
    end

    // State and pipeline registers, asynchronously reset
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= MEM_IDLE;
            rd_q      <= '0;
            wb_we_q   <= 1'b0;
            wb_dst_q  <= '0;
            wb_data_q <= '0;
            halted_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            rd_q      <= rd_d;
            wb_we_q   <= wb_we_d;
            wb_dst_q  <= wb_dst_d;
            wb_data_q <= wb_data_d;
            halted_q  <= halted_d;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_wb_stage.sv
// ============================================================================
// Module      : tb_mem_wb_stage
// Description : Self-checking bench for mem_wb_stage: directed and random
//               instructions compared against a behavioural reference model.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_wb_stage;
    import cpu_pkg::*;

    localparam int DW = 16;
    localparam int RW = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic [DW-1:0] newAddr;
    logic [2:0]    brType;
    logic          zr_flag, ov_flag, neg_flag;
    logic [DW-1:0] aluResult, mem_data, imAddrIncre;
    logic [RW-1:0] dst_addr;
    logic          we, mem_we, mem_re, hlt, labelSel;
    logic          dmem_req, dmem_wr;
    logic [DW-1:0] dmem_addr, dmem_wdata;
    logic          dmem_ack;
    logic [DW-1:0] dmem_rdata;
    logic          stall_mem, pc_redirect, flush_out;
    logic [DW-1:0] pc_target;
    logic          fwd_we;
    logic [RW-1:0] fwd_dst;
    logic [DW-1:0] fwd_data;
    logic          wb_we;
    logic [RW-1:0] wb_dst;
    logic [DW-1:0] wb_data;
    logic          halted;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_wb_stage #(.DW(DW), .RW(RW)) dut (
        .clk(clk), .rst_n(rst_n),
        .newAddr(newAddr), .brType(brType),
        .zr_flag(zr_flag), .ov_flag(ov_flag), .neg_flag(neg_flag),
        .aluResult(aluResult), .mem_data(mem_data), .imAddrIncre(imAddrIncre),
        .dst_addr(dst_addr), .we(we), .mem_we(mem_we), .mem_re(mem_re),
        .hlt(hlt), .labelSel(labelSel),
        .dmem_req(dmem_req), .dmem_wr(dmem_wr), .dmem_addr(dmem_addr),
        .dmem_wdata(dmem_wdata), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
        .stall_mem(stall_mem), .pc_redirect(pc_redirect), .pc_target(pc_target),
        .flush_out(flush_out),
        .fwd_we(fwd_we), .fwd_dst(fwd_dst), .fwd_data(fwd_data),
        .wb_we(wb_we), .wb_dst(wb_dst), .wb_data(wb_data), .halted(halted)
    );

    // Reference branch rule table
    function automatic logic ref_taken(input logic [2:0] bt, input logic z, input logic n);
        case (bt)
            3'd1:    return z;
            3'd2:    return !z;
            3'd3:    return !z && !n;
            3'd4:    return n;
            3'd5:    return z || !n;
            3'd6:    return z || n;
            3'd7:    return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

    task automatic drive_idle();
        newAddr = '0; brType = 3'b000;
        zr_flag = 0; ov_flag = 0; neg_flag = 0;
        aluResult = '0; mem_data = '0; imAddrIncre = '0; dst_addr = '0;
        we = 0; mem_we = 0; mem_re = 0; hlt = 0; labelSel = 0;
        dmem_ack = 0; dmem_rdata = '0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive_idle();
        #3;
        n_vec++; if (dmem_req !== 1'b0) begin n_err++; $display("FAIL reset_req got=%b exp=0", dmem_req); end
        n_vec++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL reset_wb_we got=%b exp=0", wb_we); end
        n_vec++; if (wb_dst !== 4'd0 || wb_data !== 16'd0) begin n_err++; $display("FAIL reset_wb got=%h/%h exp=0/0000", wb_dst, wb_data); end
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL reset_halted got=%b exp=0", halted); end
        n_vec++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL reset_stall got=%b exp=0", stall_mem); end
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // One non-memory instruction; caller sets inputs, model predicts outputs
    task automatic apply_simple(input string tag);
        logic          exp_br;
        logic [DW-1:0] exp_data;
        exp_br   = ref_taken(brType, zr_flag, neg_flag);
        exp_data = labelSel ? imAddrIncre : aluResult;
        @(negedge clk);
        n_vec++; if (stall_mem !== 1'b0) begin n_err++; $display("FAIL %s_stall got=%b exp=0", tag, stall_mem); end
        n_vec++; if (pc_redirect !== exp_br || flush_out !== exp_br) begin n_err++; $display("FAIL %s_redirect got=%b/%b exp=%b", tag, pc_redirect, flush_out, exp_br); end
        if (exp_br) begin
            n_vec++; if (pc_target !== newAddr) begin n_err++; $display("FAIL %s_target got=%h exp=%h", tag, pc_target, newAddr); end
        end
        n_vec++; if (fwd_we !== we || fwd_dst !== dst_addr || fwd_data !== exp_data) begin n_err++; $display("FAIL %s_fwd got=%b/%h/%h exp=%b/%h/%h", tag, fwd_we, fwd_dst, fwd_data, we, dst_addr, exp_data); end
        @(posedge clk); #1;
        n_vec++; if (wb_we !== we || wb_dst !== dst_addr || wb_data !== exp_data) begin n_err++; $display("FAIL %s_wb got=%b/%h/%h exp=%b/%h/%h", tag, wb_we, wb_dst, wb_data, we, dst_addr, exp_data); end
    endtask

    // One memory instruction; the ack arrives in ACCESS cycle number d+1
    task automatic run_mem(input string tag, input logic ld, input int d,
                           input logic [DW-1:0] addr, input logic [DW-1:0] wdata,
                           input logic [DW-1:0] rdata, input logic [RW-1:0] dst,
                           input logic wen, input logic [2:0] bt);
        int            stall_cnt;
        logic          exp_stall, exp_req, exp_br;
        logic [DW-1:0] exp_wb;
        stall_cnt = 0;
        drive_idle();
        mem_re = ld; mem_we = !ld; aluResult = addr; mem_data = wdata;
        dst_addr = dst; we = wen; brType = bt;
        zr_flag = 1'($urandom); neg_flag = 1'($urandom); ov_flag = 1'($urandom);
        newAddr = 16'($urandom);
        exp_wb = ld ? rdata : addr;
        for (int c = 0; c <= d + 2; c++) begin
            dmem_ack   = (c == d + 1);
            dmem_rdata = (c == d + 1) ? rdata : 16'($urandom);
            @(negedge clk);
            exp_stall = (c <= d + 1);
            exp_req   = (c >= 1) && (c <= d + 1);
            exp_br    = !exp_stall && ref_taken(bt, zr_flag, neg_flag);
            if (stall_mem === 1'b1) stall_cnt++;
            n_vec++; if (stall_mem !== exp_stall || dmem_req !== exp_req) begin n_err++; $display("FAIL %s_stall_req c=%0d got=%b/%b exp=%b/%b", tag, c, stall_mem, dmem_req, exp_stall, exp_req); end
            if (exp_req) begin
                n_vec++; if (dmem_wr !== !ld || dmem_addr !== addr || dmem_wdata !== wdata) begin n_err++; $display("FAIL %s_dmem c=%0d got=%b/%h/%h exp=%b/%h/%h", tag, c, dmem_wr, dmem_addr, dmem_wdata, !ld, addr, wdata); end
            end
            n_vec++; if (pc_redirect !== exp_br || flush_out !== exp_br) begin n_err++; $display("FAIL %s_redirect c=%0d got=%b exp=%b", tag, c, pc_redirect, exp_br); end
            n_vec++; if (fwd_we !== (wen && !exp_stall)) begin n_err++; $display("FAIL %s_fwd_we c=%0d got=%b exp=%b", tag, c, fwd_we, wen && !exp_stall); end
            if (ld && c >= d + 1) begin
                n_vec++; if (fwd_data !== rdata) begin n_err++; $display("FAIL %s_fwd_data c=%0d got=%h exp=%h", tag, c, fwd_data, rdata); end
            end
            @(posedge clk); #1;
            if (c == d + 2) begin
                n_vec++; if (wb_we !== wen) begin n_err++; $display("FAIL %s_retire got=%b exp=%b", tag, wb_we, wen); end
                if (wen) begin
                    n_vec++; if (wb_dst !== dst || wb_data !== exp_wb) begin n_err++; $display("FAIL %s_wb got=%h/%h exp=%h/%h", tag, wb_dst, wb_data, dst, exp_wb); end
                end
            end else begin
                n_vec++; if (wb_we !== 1'b0) begin n_err++; $display("FAIL %s_bubble c=%0d got=%b exp=0", tag, c, wb_we); end
            end
        end
        n_vec++; if (stall_cnt != d + 2) begin n_err++; $display("FAIL %s_stall_len got=%0d exp=%0d", tag, stall_cnt, d + 2); end
        drive_idle();
    endtask

    task automatic test_alu();
        drive_idle();
        we = 1; dst_addr = 4'd5; aluResult = 16'h1234;
        apply_simple("alu_dir");
        for (int i = 0; i < 20; i++) begin
            drive_idle();
            we = 1'($urandom); dst_addr = 4'($urandom); aluResult = 16'($urandom);
            imAddrIncre = 16'($urandom); zr_flag = 1'($urandom); neg_flag = 1'($urandom);
            apply_simple("alu_rnd");
        end
    endtask

    task automatic test_load();
        run_mem("load_dir", 1'b1, 2, 16'h0040, 16'h0000, 16'hBEEF, 4'd3, 1'b1, 3'b000);
        run_mem("load_min", 1'b1, 0, 16'h0041, 16'h0000, 16'h5A5A, 4'd7, 1'b1, 3'b000);
    endtask

    task automatic test_branch();
        drive_idle(); brType = BR_EQ; zr_flag = 1; newAddr = 16'h0100;
        apply_simple("beq_t");
        drive_idle(); brType = BR_EQ; zr_flag = 0; newAddr = 16'h0100;
        apply_simple("beq_nt");
        for (int i = 0; i < 24; i++) begin
            drive_idle();
            brType = 3'($urandom); zr_flag = 1'($urandom); neg_flag = 1'($urandom);
            ov_flag = 1'($urandom); newAddr = 16'($urandom); aluResult = 16'($urandom);
            apply_simple("br_rnd");
        end
    endtask

    task automatic test_label_store();
        drive_idle(); labelSel = 1; imAddrIncre = 16'h0021; dst_addr = 4'd15; we = 1;
        aluResult = 16'h7777;
        apply_simple("label");
        run_mem("store", 1'b0, 1, 16'h0080, 16'hCAFE, 16'h0000, 4'd2, 1'b0, 3'b000);
    endtask

    task automatic test_mem_branch();
        run_mem("ld_br", 1'b1, 1, 16'h0010, 16'h0000, 16'h1111, 4'd4, 1'b1, BR_UNCOND);
    endtask

    task automatic test_back_to_back();
        for (int i = 0; i < 12; i++) begin
            if ($urandom_range(0, 2) == 0) begin
                drive_idle();
                we = 1'($urandom); dst_addr = 4'($urandom); aluResult = 16'($urandom);
                brType = 3'($urandom); zr_flag = 1'($urandom); neg_flag = 1'($urandom);
                newAddr = 16'($urandom);
                apply_simple("b2b_alu");
            end else begin
                run_mem("b2b_mem", 1'($urandom), $urandom_range(0, 4), 16'($urandom),
                        16'($urandom), 16'($urandom), 4'($urandom), 1'($urandom), 3'($urandom));
            end
        end
    endtask

    task automatic test_reset_mid();
        drive_idle();
        mem_re = 1; aluResult = 16'h0200; we = 1; dst_addr = 4'd9;
        @(posedge clk); #1;
        @(negedge clk);
        n_vec++; if (dmem_req !== 1'b1) begin n_err++; $display("FAIL rstmid_pre_req got=%b exp=1", dmem_req); end
        #1 rst_n = 1'b0;
        #1;
        n_vec++; if (dmem_req !== 1'b0 || wb_we !== 1'b0 || halted !== 1'b0) begin n_err++; $display("FAIL rstmid_async got=%b/%b/%b exp=0/0/0", dmem_req, wb_we, halted); end
        drive_idle();
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        run_mem("post_rst", 1'b1, 1, 16'h0300, 16'h0000, 16'h2468, 4'd6, 1'b1, 3'b000);
    endtask

    task automatic test_halt();
        drive_idle(); dmem_ack = 1; dmem_rdata = 16'hDEAD;
        @(negedge clk);
        n_vec++; if (stall_mem !== 1'b0 || dmem_req !== 1'b0) begin n_err++; $display("FAIL stray_ack got=%b/%b exp=0/0", stall_mem, dmem_req); end
        @(posedge clk); #1;
        dmem_ack = 0;
        @(negedge clk);
        n_vec++; if (stall_mem !== 1'b0 || dmem_req !== 1'b0) begin n_err++; $display("FAIL stray_after got=%b/%b exp=0/0", stall_mem, dmem_req); end
        @(posedge clk); #1;
        run_mem("post_stray", 1'b1, 0, 16'h0050, 16'h0000, 16'h0F0F, 4'd1, 1'b1, 3'b000);
        drive_idle(); hlt = 1;
        @(negedge clk);
        n_vec++; if (halted !== 1'b0) begin n_err++; $display("FAIL halt_pre got=%b exp=0", halted); end
        @(posedge clk); #1;
        n_vec++; if (halted !== 1'b1) begin n_err++; $display("FAIL halt_set got=%b exp=1", halted); end
        drive_idle(); mem_re = 1; mem_we = 1'($urandom); aluResult = 16'h0060;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            n_vec++; if (dmem_req !== 1'b0 || halted !== 1'b1) begin n_err++; $display("FAIL halt_noreq c=%0d got=%b/%b exp=0/1", i, dmem_req, halted); end
            @(posedge clk); #1;
        end
        drive_idle();
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_branch();
        test_label_store();
        test_mem_branch();
        test_back_to_back();
        test_reset_mid();
        test_halt();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
